// File: rtl/map_pkg.sv
// map_pkg: shared constants and types for the map renderer.
//   - Tile codes stored in the Sokoban map.
//   - RGB444 colour constants ({r,g,b}).
//   - GRID_LOG2: the map is 2^GRID_LOG2 tiles on each side.
//   - pix_t: per-pixel side information that travels down the pipeline.
package map_pkg;

  localparam int GRID_LOG2 = 3;

  typedef enum logic [3:0] {
    TILE_FLOOR    = 4'd0,
    TILE_WALL     = 4'd1,
    TILE_BOX      = 4'd2,
    TILE_BOX_DEST = 4'd3,
    TILE_DEST     = 4'd4
  } tile_e;

  localparam logic [11:0] COL_BLACK    = 12'h000;
  localparam logic [11:0] COL_BORDER   = 12'h444;
  localparam logic [11:0] COL_WIN      = 12'h0F0;
  localparam logic [11:0] COL_PLAYER   = 12'h00F;
  localparam logic [11:0] COL_WALL     = 12'h842;
  localparam logic [11:0] COL_MORTAR   = 12'hCCC;
  localparam logic [11:0] COL_BOX      = 12'hA60;
  localparam logic [11:0] COL_BOX_EDGE = 12'h530;
  localparam logic [11:0] COL_BOX_DEST = 12'h0A0;
  localparam logic [11:0] COL_FLOOR    = 12'h888;
  localparam logic [11:0] COL_MARKER   = 12'hF00;

  // Pixel offset inside its tile plus the region flags and blanking.
  typedef struct packed {
    logic [4:0] ox;
    logic [4:0] oy;
    logic       in_area;
    logic       in_border;
    logic       rdn;
  } pix_t;

  // Blanked (rdn=1) so a freshly reset pipeline emits black.
  localparam pix_t PIX_RESET = '{ox: 5'd0, oy: 5'd0, in_area: 1'b0,
                                 in_border: 1'b0, rdn: 1'b1};

  // Inclusive range test on a tile offset.
  function automatic logic in_range(input logic [4:0] v,
                                    input logic [4:0] lo,
                                    input logic [4:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/tile_color.sv
// tile_color: purely combinational colour function for one pixel.
// Ports:
//   tile_i       map tile code under the pixel
//   ox_i, oy_i   pixel offset inside the 32x32 tile
//   is_player_i  pixel lies on the player sprite
//   blink_i      destination marker currently visible
//   win_i        level-complete snapshot (border colour)
//   in_area_i    pixel inside the 256x256 play area
//   in_border_i  pixel on the 4-pixel ring around the area
//   rdn_i        active-low display enable (1 = blanking)
//   color_o      RGB444 colour
module tile_color
  import map_pkg::*;
(
  input  logic [3:0]  tile_i,
  input  logic [4:0]  ox_i,
  input  logic [4:0]  oy_i,
  input  logic        is_player_i,
  input  logic        blink_i,
  input  logic        win_i,
  input  logic        in_area_i,
  input  logic        in_border_i,
  input  logic        rdn_i,
  output logic [11:0] color_o
);

  logic box_edge;
  logic marker_px;

  assign box_edge  = (ox_i < 5'd2) || (ox_i > 5'd29) ||
                     (oy_i < 5'd2) || (oy_i > 5'd29);
  assign marker_px = in_range(ox_i, 5'd12, 5'd19) && in_range(oy_i, 5'd12, 5'd19);

  // NOTE: color_o gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    color_o = COL_BLACK;
    if (rdn_i) begin
      color_o = COL_BLACK;
    end else if (in_border_i) begin
      color_o = win_i ? COL_WIN : COL_BORDER;
    end else if (!in_area_i) begin
      color_o = COL_BLACK;
    end else if (is_player_i) begin
      color_o = COL_PLAYER;
    end else begin
      case (tile_i)
        TILE_WALL: begin
          // Brick pattern: horizontal joints every 8 rows, vertical every 16 columns.
          color_o = ((oy_i[2:0] == 3'd0) || (ox_i[3:0] == 4'd0)) ? COL_MORTAR : COL_WALL;
        end
        TILE_BOX:      color_o = box_edge ? COL_BOX_EDGE : COL_BOX;
        TILE_BOX_DEST: color_o = COL_BOX_DEST;
        TILE_DEST:     color_o = (blink_i && marker_px) ? COL_MARKER : COL_FLOOR;
        default:       color_o = COL_FLOOR;
      endcase
    end
  end

endmodule

// File: rtl/map_renderer.sv
// map_renderer: pixel source for the VGA controller. Converts the scan
// position into an RGB444 colour with a fixed 3-cycle latency, reading the
// 8x8 map through a synchronous port and overlaying player, blinking
// destination marker and win border.
// Ports:
//   clk, rstn            pixel clock, asynchronous active-low reset
//   row_addr, col_addr   scan position from the VGA controller
//   rdn                  active-low display enable
//   map_x, map_y         registered map read address (column, row)
//   map_tile             tile code, valid one cycle after the address
//   p_x, p_y, win        player tile and level-complete flag (per-frame sampled)
//   vgac_in              registered RGB444 colour
module map_renderer
  import map_pkg::*;
#(
  parameter int TILE_LOG2 = 5,
  parameter int X0        = 192,
  parameter int Y0        = 112
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  output logic [2:0]  map_x,
  output logic [2:0]  map_y,
  input  logic [3:0]  map_tile,
  input  logic [2:0]  p_x,
  input  logic [2:0]  p_y,
  input  logic        win,
  output logic [11:0] vgac_in
);

  localparam logic [10:0] X0_W   = 11'(X0);
  localparam logic [10:0] Y0_W   = 11'(Y0);
  localparam logic [10:0] AREA_W = 11'(1 << (TILE_LOG2 + GRID_LOG2));
  localparam logic [10:0] RING_W = 11'd4;

  // ---------------------------------------------------------------
  // Frame tracking and per-frame snapshots
  // ---------------------------------------------------------------
  logic [8:0] row_q;
  logic       frame_start;
  logic [4:0] frame_cnt_q;
  logic [2:0] px_snap_q, py_snap_q;
  logic       win_snap_q;

  assign frame_start = (row_addr == 9'd0) && (row_q != 9'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q       <= 9'd0;
      frame_cnt_q <= 5'd0;
      px_snap_q   <= 3'd0;
      py_snap_q   <= 3'd0;
      win_snap_q  <= 1'b0;
    end else begin
      row_q <= row_addr;
      // Player/win are only sampled here, so mid-frame changes never tear.
      if (frame_start) begin
        frame_cnt_q <= frame_cnt_q + 5'd1;
        px_snap_q   <= p_x;
        py_snap_q   <= p_y;
        win_snap_q  <= win;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 0: address decode
  // ---------------------------------------------------------------
  logic [10:0] col_w, row_w;
  logic [9:0]  dx, dy;
  logic        in_area_d, in_ring_d;
  logic [2:0]  map_x_d, map_y_d;
  pix_t        s0_d;

  assign col_w = {1'b0, col_addr};
  assign row_w = {2'b00, row_addr};
  assign dx    = col_addr - X0_W[9:0];
  assign dy    = {1'b0, row_addr} - Y0_W[9:0];

  assign in_area_d = (col_w >= X0_W) && (dx < AREA_W[9:0]) &&
                     (row_w >= Y0_W) && (dy < AREA_W[9:0]);

  // Ring bounds are checked with +RING_W on the left side so nothing underflows.
  assign in_ring_d = (col_w + RING_W >= X0_W) && (col_w < X0_W + AREA_W + RING_W) &&
                     (row_w + RING_W >= Y0_W) && (row_w < Y0_W + AREA_W + RING_W);

  assign map_x_d = dx[TILE_LOG2+GRID_LOG2-1:TILE_LOG2];
  assign map_y_d = dy[TILE_LOG2+GRID_LOG2-1:TILE_LOG2];

  // Offsets are 5 bits wide; the sprite and tile patterns are drawn for 32-pixel tiles.
  assign s0_d = '{ox:        dx[4:0],
                  oy:        dy[4:0],
                  in_area:   in_area_d,
                  in_border: in_ring_d && !in_area_d,
                  rdn:       rdn};

  logic [2:0] map_x_q, map_y_q;
  pix_t       s0_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      map_x_q <= 3'd0;
      map_y_q <= 3'd0;
      s0_q    <= PIX_RESET;
    end else begin
      map_x_q <= map_x_d;
      map_y_q <= map_y_d;
      s0_q    <= s0_d;
    end
  end

  assign map_x = map_x_q;
  assign map_y = map_y_q;

  // ---------------------------------------------------------------
  // Stage 1: map read (tile returned for the stage-0 address)
  // ---------------------------------------------------------------
  logic [3:0] tile1_q;
  logic [2:0] tx1_q, ty1_q;
  pix_t       s1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tile1_q <= 4'd0;
      tx1_q   <= 3'd0;
      ty1_q   <= 3'd0;
      s1_q    <= PIX_RESET;
    end else begin
      tile1_q <= map_tile;
      tx1_q   <= map_x_q;
      ty1_q   <= map_y_q;
      s1_q    <= s0_q;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: colour
  // ---------------------------------------------------------------
  logic        is_player;
  logic [11:0] color_d;
  logic [11:0] vgac_q;

  assign is_player = (tx1_q == px_snap_q) && (ty1_q == py_snap_q) &&
                     in_range(s1_q.ox, 5'd8, 5'd23) && in_range(s1_q.oy, 5'd8, 5'd23);

  tile_color u_tile_color (
    .tile_i      (tile1_q),
    .ox_i        (s1_q.ox),
    .oy_i        (s1_q.oy),
    .is_player_i (is_player),
    .blink_i     (frame_cnt_q[4]),
    .win_i       (win_snap_q),
    .in_area_i   (s1_q.in_area),
    .in_border_i (s1_q.in_border),
    .rdn_i       (s1_q.rdn),
    .color_o     (color_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vgac_q <= COL_BLACK;
    end else begin
      vgac_q <= color_d;
    end
  end

  assign vgac_in = vgac_q;

endmodule

// File: tb/tb_map_renderer.sv
// Testbench for map_renderer. Stimulus pushes the hand-computed colour for
// each issued pixel into a scoreboard tagged with the cycle it must appear;
// an independent monitor pops and compares on the falling clock edge.
module tb_map_renderer;
  import map_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [2:0]  map_x, map_y;
  logic [3:0]  map_tile;
  logic [2:0]  p_x, p_y;
  logic        win;
  logic [11:0] vgac_in;

  always #5 clk = ~clk;

  map_renderer #(.TILE_LOG2(5), .X0(192), .Y0(112)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .rdn      (rdn),
    .map_x    (map_x),
    .map_y    (map_y),
    .map_tile (map_tile),
    .p_x      (p_x),
    .p_y      (p_y),
    .win      (win),
    .vgac_in  (vgac_in)
  );

  // Map model, indexed [x][y]; answers the registered address combinationally.
  logic [3:0] tiles [8][8];
  assign map_tile = tiles[map_x][map_y];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [4:0] fc = 5'd0;   // model of the frame counter

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the colour due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no sample taken at cycle %0d, expected %h", mon_e.name, mon_e.due, mon_e.exp);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.name, vgac_in, mon_e.exp);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      row_addr = 9'd400;
      col_addr = 10'd600;
      rdn      = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pix(input int col, input int row, input logic r,
                     input logic [11:0] exp, input string name);
    row_addr = row[8:0];
    col_addr = col[9:0];
    rdn      = r;
    sb.push_back('{due: cyc + 3, exp: exp, name: name});
    @(negedge clk);
  endtask

  task automatic new_frame();
    idle(4);
    row_addr = 9'd0;
    col_addr = 10'd600;
    @(negedge clk);
    fc = fc + 5'd1;
    idle(1);
  endtask

  initial begin
    int guard;
    rstn     = 1'b0;
    row_addr = 9'd400;
    col_addr = 10'd600;
    rdn      = 1'b0;
    p_x      = 3'd0;
    p_y      = 3'd0;
    win      = 1'b0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        tiles[x][y] = 4'd0;
    tiles[0][0] = 4'd1;   // wall
    tiles[1][1] = 4'd2;   // box
    tiles[2][1] = 4'd3;   // box on destination
    tiles[6][6] = 4'd4;   // destination

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_vgac", vgac_in, 12'h000);
    check("rst_map_x", {9'd0, map_x}, 12'd0);
    check("rst_map_y", {9'd0, map_y}, 12'd0);
    check("rst_frame_cnt", {7'd0, dut.frame_cnt_q}, 12'd0);
    rstn = 1'b1;
    idle(2);

    // Wall at the origin tile, address registration
    pix(192, 112, 1'b0, 12'hCCC, "wall_mortar_origin");
    check("map_x_origin", {9'd0, map_x}, 12'd0);
    check("map_y_origin", {9'd0, map_y}, 12'd0);
    pix(355, 304, 1'b0, 12'h888, "floor_5_6");
    check("map_x_5", {9'd0, map_x}, 12'd5);
    check("map_y_6", {9'd0, map_y}, 12'd6);
    pix(193, 113, 1'b0, 12'h842, "wall_body");
    pix(208, 115, 1'b0, 12'hCCC, "wall_mortar_vert");

    // Boxes
    pix(224, 144, 1'b0, 12'h530, "box_edge");
    pix(234, 154, 1'b0, 12'hA60, "box_body");
    pix(255, 173, 1'b0, 12'h530, "box_edge_hi");
    pix(261, 150, 1'b0, 12'h0A0, "box_dest");

    // Player at (3,2)
    p_x = 3'd3;
    p_y = 3'd2;
    new_frame();
    pix(304, 192, 1'b0, 12'h00F, "player_centre");
    pix(290, 192, 1'b0, 12'h888, "player_ox2");
    pix(311, 192, 1'b0, 12'h00F, "player_ox23");
    pix(312, 192, 1'b0, 12'h888, "player_ox24");
    pix(304, 183, 1'b0, 12'h888, "player_oy7");

    // Destination marker blinking over 32 frames
    for (int i = 0; i < 32; i++) begin
      new_frame();
      pix(400, 320, 1'b0, fc[4] ? 12'hF00 : 12'h888, "dest_centre");
      pix(395, 320, 1'b0, 12'h888, "dest_offcentre");
    end
    idle(1);
    check("frame_cnt_model", {7'd0, dut.frame_cnt_q}, {7'd0, fc});

    // Win raised mid-frame only shows after the next frame start
    win = 1'b1;
    idle(1);
    pix(190, 200, 1'b0, 12'h444, "border_prewin");
    new_frame();
    pix(190, 200, 1'b0, 12'h0F0, "border_win");
    pix(200, 200, 1'b1, 12'h000, "rdn_blank");
    pix(447, 200, 1'b0, 12'h888, "last_col_tile7");
    pix(448, 200, 1'b0, 12'h0F0, "border_right");
    pix(451, 200, 1'b0, 12'h0F0, "border_right_edge");
    pix(452, 200, 1'b0, 12'h000, "outside_ring");
    pix(300, 108, 1'b0, 12'h0F0, "border_top");
    pix(300, 107, 1'b0, 12'h000, "above_ring");

    // p_x change coinciding with frame start is latched; mid-frame change is not
    idle(4);
    row_addr = 9'd0;
    col_addr = 10'd600;
    p_x      = 3'd5;
    @(negedge clk);
    fc  = fc + 5'd1;
    p_x = 3'd0;
    idle(1);
    pix(368, 192, 1'b0, 12'h00F, "player_latched_at_fs");
    pix(304, 192, 1'b0, 12'h888, "old_player_gone");

    // Reset asserted mid-frame with a coloured pixel on the output
    idle(4);
    row_addr = 9'd304;
    col_addr = 10'd355;
    rdn      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_vgac", vgac_in, 12'h888);
    rstn = 1'b0;
    #1;
    check("midrst_vgac", vgac_in, 12'h000);
    check("midrst_map_x", {9'd0, map_x}, 12'd0);
    check("midrst_frame_cnt", {7'd0, dut.frame_cnt_q}, 12'd0);
    @(negedge clk);
    rstn = 1'b1;
    sb.push_back('{due: cyc + 1, exp: 12'h000, name: "post_rst_1"});
    sb.push_back('{due: cyc + 2, exp: 12'h000, name: "post_rst_2"});
    sb.push_back('{due: cyc + 3, exp: 12'h888, name: "post_rst_3"});
    repeat (3) @(negedge clk);

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/map_renderer.md
# map_renderer

Pixel-source stage that sits directly upstream of the VGA controller inside TOP. It turns the controller's `row_addr`/`col_addr` scan position into the 12-bit `vgac_in` colour. It reads the 8x8 Sokoban map held in the game-logic block through a synchronous read port and overlays the player sprite, a blinking destination marker and a win border. It is clocked by the VGA pixel clock and has a fixed 3-cycle pipeline latency.

## Interface
Parameters:
- `TILE_LOG2`, 5: tile edge is 2^TILE_LOG2 pixels (32).
- `X0`, 192: first play-area column (centres the 256-pixel area in 640).
- `Y0`, 112: first play-area row (centres the 256-pixel area in 480).

Ports:
- `clk` in 1: VGA pixel clock (the same clock as the VGA controller). Single clock domain.
- `rstn` in 1: asynchronous, active-low reset.
- `row_addr` in 9: current scan row, 0..479.
- `col_addr` in 10: current scan column, 0..639.
- `rdn` in 1: active-low display-enable from the VGA controller.
- `map_x` out 3: map read column address.
- `map_y` out 3: map read row address.
- `map_tile` in 4: value of `cur_map[map_x][map_y]`, valid one cycle after the address.
- `p_x`, `p_y` in 3 each: player tile position.
- `win` in 1: level-complete flag.
- `vgac_in` out 12: RGB444 pixel colour, {r,g,b}.

## Operation
- Frame start: `frame_start` pulses for one cycle when `row_addr`==0 and the registered previous row was nonzero.
- Per-frame latching: on `frame_start`, latch `p_x`, `p_y` and `win` into snapshot registers, and increment the 5-bit `frame_cnt` (wraps 31->0).
- Blink: the destination marker is visible when `frame_cnt[4]`==1, i.e. it toggles every 16 frames.
- Stage 0 (address decode):
  - dx = col_addr-X0 and dy = row_addr-Y0, both 10-bit unsigned.
  - `in_area` = (col_addr>=X0 && dx<256 && row_addr>=Y0 && dy<256).
  - `in_border` = not `in_area`, but inside the 4-pixel ring around the area (col X0-4..X0+259, row Y0-4..Y0+259).
  - `map_x` = dx[7:5] and `map_y` = dy[7:5] are registered outputs.
  - Registered alongside them: offsets ox = dx[4:0] and oy = dy[4:0], the flags, and `rdn`.
- Stage 1 (map read): `map_tile` is sampled. Tile coordinate, offsets, flags and `rdn` are forwarded.
- Stage 2 (colour): the sub-module computes the colour, which is registered into `vgac_in`. Colours by priority:
  - `rdn`==1 gives 12'h000.
  - `in_border` gives 12'h0F0 if the `win` snapshot is set, else 12'h444.
  - Not in area gives 12'h000.
  - Player: tile equals the (p_x,p_y) snapshot and ox,oy are both in 8..23 gives 12'h00F.
  - Otherwise the tile code decides:
    - Code 1, wall: 12'h842; mortar 12'hCCC when oy[2:0]==0 or ox[3:0]==0.
    - Code 2, box: 12'hA60; 2-pixel edge 12'h530 (ox or oy <2 or >29).
    - Code 3, box on destination: 12'h0A0.
    - Code 4, destination: 12'h888; centre ox,oy in 12..19 is 12'hF00 when blink is on.
    - Codes 0 and 5..15: floor, 12'h888.

## Timing
- Latency is exactly 3 `clk` edges from address to `vgac_in`. X0 and Y0 are pixel positions before latency, so the horizontal shift of 3 pixels is accepted.
- `map_x`/`map_y` change at edge t+1 for the address applied at t. The logic block must return `map_tile` by edge t+2.
- Reset values: `vgac_in`=12'h000, `map_x`=`map_y`=0, `frame_cnt`=0, snapshots=0, pipeline flags=0 and `rdn` pipe=1.
- Reset asserted mid-frame clears everything immediately. After release, output is black until new addresses propagate (3 cycles).
- `p_x`/`p_y`/`win` changes mid-frame are not visible until the next `frame_start`, so there is no tearing.
- Column boundaries: col X0 maps to tile 0, ox 0. Col X0+255 maps to tile 7, ox 31. Col X0+256 is border.
- `frame_start` coinciding with a `p_x` change latches the new value.

## Structure
- Package `map_pkg`:
  - Tile codes: TILE_FLOOR=0, WALL=1, BOX=2, BOX_DEST=3, DEST=4.
  - All 12-bit colour constants.
  - GRID_LOG2=3.
- Sub-module `tile_color`: combinational colour function of (tile, ox, oy, is_player, blink, flags). Stage-2 register stays in the parent.

## Test plan
- Reset with `rstn` low for 5 cycles -> `vgac_in`=000, `map_x`/`map_y`=0, `frame_cnt`=0.
- Scan col 192, row 112 with `map_tile`=1 -> `map_x`=0/`map_y`=0 one cycle later. `vgac_in`=CCC (mortar, oy=0) 3 cycles after the address. At row 113, col 193 -> 842.
- Player at (3,2), tile 0, col 192+96+16, row 112+64+16 -> 00F. Same tile, ox=2 -> 888.
- Tile 4 at the centre pixel, over 32 frames -> F00 during 16 frames, 888 during the other 16.
- `win`=1 raised mid-frame, col 190, row 200 -> 444 for the rest of the frame, 0F0 after the next `frame_start`. `rdn`=1 at any position -> 000.
- Col 448 (X0+256), row 200 -> border colour. Col 452 -> 000.
